pattern_burst_uart: RTL
=======================

# pattern_burst_uart

Parametrised test-traffic source for board bring-up. It emits bursts of BURST pattern words every PERIOD clocks into an internal fifo_uart, which serialises them on o_tx. Pattern mode is selectable at run time: Johnson, incrementing, or PRBS. FIFO backpressure is honoured rather than writing blindly, and missed burst slots are reported. It sits at the top of test designs in place of a fixed counter-driven pattern source.

## Interface
- WIDTH, 8: data word width, 2..16.
- DIVISOR, 9: UART clocks per bit, passed to fifo_uart.
- DEPTH, 8: FIFO depth, passed to fifo_uart.
- LEVEL, 2: almost-full/almost-empty threshold, passed to fifo_uart.
- PERIOD, 1000000: clocks between burst slots, ≥ 2.
- BURST, 4: payload words per burst, 1..DEPTH (1..DEPTH-1 with header enabled).
- clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_gen_en  in  1  enables the period counter and burst generation.
- i_tx_en  in  1  enables UART transmission; drives fifo_uart i_enable.
- i_mode  in  2  pattern select: 00 Johnson, 01 increment, 10 PRBS, 11 treated as 01.
- o_tx  out  1  UART serial output; idle high.
- o_busy  out  1  high when FSM is not in IDLE.
- o_stall  out  1  high in a write state while FIFO is full.
- o_overrun  out  1  sticky: a burst slot arrived while the previous burst was unfinished.
- o_burst_cnt  out  16  completed bursts, wraps 0xFFFF→0.

## Operation
- Period counter runs 0..PERIOD-1 while i_gen_en=1, then wraps. It holds its value while i_gen_en=0. Slot pulse = i_gen_en && cnt==PERIOD-1.
- FSM states: IDLE, HDR (macro only), FILL.
  - IDLE→FILL (or HDR) on slot pulse.
  - HDR→FILL after its single write.
  - FILL→IDLE on the write that takes words_left from 1 to 0; o_burst_cnt increments on that edge.
- On entry from IDLE: i_mode is latched into mode_q and words_left=BURST. If mode_q changes, the newly selected generator is reseeded.
- Write strobe w_en = (state is HDR or FILL) && !full. This is combinational from fifo_uart o_full; the word is captured on that edge.
- Full FIFO: hold state, data and words_left. o_stall=1. No word is dropped.
- A slot pulse while not IDLE sets o_overrun and is otherwise ignored. o_overrun clears only on reset.
- Generators advance only on a FILL write; HDR writes do not advance them.
  - Johnson: seed all-ones; next = {w[WIDTH-2:0], ~w[WIDTH-1]}.
  - Increment: seed 0; next = w+1, modulo 2^WIDTH.
  - PRBS: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seed 16'hACE1. Shift left, feedback into bit 0. Word = lfsr[WIDTH-1:0].
- Reset mid-burst: FSM to IDLE, counters 0, generators reseeded, FIFO flushed via fifo_uart reset, o_tx forced high.

## Timing
- Reset values: o_tx=1, o_busy=0, o_stall=0, o_overrun=0, o_burst_cnt=0, period counter 0.
- Slot pulse at cycle N: o_busy=1 at N+1; first w_en at N+1 if not full. First word is written on the N+1→N+2 edge.
- An unstalled burst occupies BURST cycles in FILL (BURST+1 with header). o_busy falls the cycle after the last write.
- o_stall is combinational and follows full within the same cycle.
- Start bit on o_tx appears at the fifo_uart read latency after the first write, provided i_tx_en=1.

## Configuration
- PATTERN_BURST_HEADER_EN defined: each burst begins with one HDR word equal to o_burst_cnt[WIDTH-1:0] (for WIDTH>16, zero-extended), written before payload.
- Not defined: no HDR state; bursts are payload only.

## Test plan
- Reset asserted mid-burst, released -> all outputs at reset values, o_tx high, next slot starts fresh from seed.
- WIDTH=8, PERIOD=200, BURST=4, DIVISOR=4, mode 01, tx enabled -> o_tx frames 00,01,02,03, then 04,05,06,07; o_burst_cnt=2.
- Mode 00 -> frames FF,FE,FC,F8. Mode 10 -> first frame E1. Switch 00→01 between bursts -> next burst starts at 00.
- i_tx_en=0, DEPTH=8, BURST=4, PERIOD=20 -> second burst fills FIFO; third burst o_stall=1. A slot during the stall -> o_overrun=1. Set i_tx_en=1 -> FIFO drains, burst completes, no word lost.
- With PATTERN_BURST_HEADER_EN, mode 01 -> frames 00,00,01,02,03 then 01,04,05,06,07.
- i_gen_en dropped mid-period for 50 cycles -> slot delayed by exactly 50 cycles, no overrun.

Source files
------------

// File: rtl/pattern_burst_uart.sv
// pattern_burst_uart: bring-up traffic source. Every PERIOD clocks a burst of
// BURST pattern words (Johnson, increment or PRBS) is written into an internal
// FIFO-fed UART transmitter. Writes respect FIFO full; late slots are flagged.
// Optional build macro: PATTERN_BURST_HEADER_EN prefixes each burst with one
// header word holding the completed-burst count.

// Small FIFO in front of an 8N1-style serialiser (start, WIDTH data LSB first, stop).
module fifo_uart #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 9,
    parameter int DEPTH   = 8,
    parameter int LEVEL   = 2
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_tx
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BAUD_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int BIT_W  = $clog2(WIDTH + 2);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              active_q;
    logic [BAUD_W-1:0] baud_q;
    logic [BIT_W-1:0]  bits_q;
    logic [WIDTH:0]    shreg_q;
    logic              tx_q;
    logic              wr_s, rd_s;

    // Accept writes only when there is room; pop when the serialiser is free.
    always_comb begin
        wr_s = i_wr && (count_q != CNT_W'(DEPTH));
        rd_s = !active_q && i_enable && (count_q != CNT_W'(0));
    end

    assign o_full         = (count_q == CNT_W'(DEPTH));
    assign o_almost_full  = (count_q >= CNT_W'(DEPTH - LEVEL));
    assign o_almost_empty = (count_q <= CNT_W'(LEVEL));
    assign o_tx           = tx_q;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            if (wr_s) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
            end
            if (rd_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Serialiser: a popped word goes out as start bit, data bits, stop bit.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            baud_q   <= BAUD_W'(0);
            bits_q   <= BIT_W'(0);
            shreg_q  <= {(WIDTH + 1){1'b0}};
        end else if (rd_s) begin
            active_q <= 1'b1;
            tx_q     <= 1'b0;
            baud_q   <= BAUD_W'(0);
            bits_q   <= BIT_W'(WIDTH + 1);
            shreg_q  <= {1'b1, mem_q[rd_ptr_q]};
        end else if (active_q) begin
            if (baud_q == BAUD_W'(DIVISOR - 1)) begin
                baud_q <= BAUD_W'(0);
                if (bits_q == BIT_W'(0)) begin
                    active_q <= 1'b0;
                end else begin
                    tx_q    <= shreg_q[0];
                    shreg_q <= {1'b1, shreg_q[WIDTH:1]};
                    bits_q  <= bits_q - BIT_W'(1);
                end
            end else begin
                baud_q <= baud_q + BAUD_W'(1);
            end
        end
    end
endmodule

module pattern_burst_uart #(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 9,
    parameter int DEPTH   = 8,
    parameter int LEVEL   = 2,
    parameter int PERIOD  = 1000000,
    parameter int BURST   = 4
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_gen_en,
    input  logic        i_tx_en,
    input  logic [1:0]  i_mode,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_stall,
    output logic        o_overrun,
    output logic [15:0] o_burst_cnt
);
    localparam int          CNT_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int          WL_W      = $clog2(BURST + 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    // One Johnson step: shift left, complement of the MSB enters at bit 0.
    function automatic logic [WIDTH-1:0] johnson_step(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], ~w[WIDTH-1]};
    endfunction

    // One PRBS step: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        mode_q;
    logic [WL_W-1:0]   words_left_q;
    logic [15:0]       burst_cnt_q;
    logic              overrun_q;
    logic [WIDTH-1:0]  john_q, john_d;
    logic [WIDTH-1:0]  inc_q, inc_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic              slot_s, in_write_s, w_en_s, reseed_s, adv_s;
    logic [1:0]        mode_norm_s;
    logic [WIDTH-1:0]  wr_data_s;
    logic              fifo_full_s;
    logic              unused_afull_s, unused_aempty_s;

    // Slot detection, write strobe and the word presented to the FIFO.
    always_comb begin
        slot_s      = i_gen_en && (cnt_q == CNT_W'(PERIOD - 1));
        mode_norm_s = (i_mode == 2'b11) ? 2'b01 : i_mode;
        in_write_s  = (state_q == ST_HDR) || (state_q == ST_FILL);
        w_en_s      = in_write_s && !fifo_full_s;
        reseed_s    = (state_q == ST_IDLE) && slot_s && (mode_norm_s != mode_q);
        adv_s       = w_en_s && (state_q == ST_FILL);
        if (state_q == ST_HDR) begin
            wr_data_s = burst_cnt_q[WIDTH-1:0];
        end else begin
            case (mode_q)
                2'b00:   wr_data_s = john_q;
                2'b10:   wr_data_s = lfsr_q[WIDTH-1:0];
                default: wr_data_s = inc_q;
            endcase
        end
    end

    // Generator next state: reseed on a mode switch at burst start, step on payload writes.
    always_comb begin
        john_d = john_q;
        inc_d  = inc_q;
        lfsr_d = lfsr_q;
        if (reseed_s) begin
            case (mode_norm_s)
                2'b00:   john_d = {WIDTH{1'b1}};
                2'b10:   lfsr_d = LFSR_SEED;
                default: inc_d  = {WIDTH{1'b0}};
            endcase
        end else if (adv_s) begin
            case (mode_q)
                2'b00:   john_d = johnson_step(john_q);
                2'b10:   lfsr_d = lfsr_step(lfsr_q);
                default: inc_d  = inc_q + WIDTH'(1'b1);
            endcase
        end else begin
            john_d = john_q;
            inc_d  = inc_q;
            lfsr_d = lfsr_q;
        end
    end

    // Pattern generator registers.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            john_q <= {WIDTH{1'b1}};
            inc_q  <= {WIDTH{1'b0}};
            lfsr_q <= LFSR_SEED;
        end else begin
            john_q <= john_d;
            inc_q  <= inc_d;
            lfsr_q <= lfsr_d;
        end
    end

    // Period counter: wraps at PERIOD-1, frozen while generation is disabled.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q <= CNT_W'(0);
        end else if (i_gen_en) begin
            cnt_q <= (cnt_q == CNT_W'(PERIOD - 1)) ? CNT_W'(0) : cnt_q + CNT_W'(1);
        end
    end

    // Burst FSM with overrun flag and completed-burst counter.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'b01;
            words_left_q <= WL_W'(0);
            burst_cnt_q  <= 16'd0;
            overrun_q    <= 1'b0;
        end else begin
            if (slot_s && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (slot_s) begin
                        mode_q       <= mode_norm_s;
                        words_left_q <= WL_W'(BURST);
`ifdef PATTERN_BURST_HEADER_EN
                        state_q      <= ST_HDR;
`else
                        state_q      <= ST_FILL;
`endif
                    end
                end
                ST_HDR: begin
                    if (w_en_s) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_en_s) begin
                        words_left_q <= words_left_q - WL_W'(1);
                        if (words_left_q == WL_W'(1)) begin
                            state_q     <= ST_IDLE;
                            burst_cnt_q <= burst_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_stall     = in_write_s && fifo_full_s;
    assign o_overrun   = overrun_q;
    assign o_burst_cnt = burst_cnt_q;

    fifo_uart #(
        .WIDTH   (WIDTH),
        .DIVISOR (DIVISOR),
        .DEPTH   (DEPTH),
        .LEVEL   (LEVEL)
    ) u_fifo_uart (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_enable       (i_tx_en),
        .i_wr           (w_en_s),
        .i_data         (wr_data_s),
        .o_full         (fifo_full_s),
        .o_almost_full  (unused_afull_s),
        .o_almost_empty (unused_aempty_s),
        .o_tx           (o_tx)
    );
endmodule
